// File: rtl/io_stream_bridge.sv
// io_stream_bridge
//   Host-side endpoint for the processor din/dout buses. The host pushes
//   words into an input FIFO whose head drives din for storedin. Words that
//   the processor strobes out on dout during senddout are captured into an
//   output FIFO, which the host drains.
//   Both FIFOs are first-word-fall-through. Each one has a registered count
//   and wrapping read/write pointers.
//   Optional feature: define IO_STREAM_BRIDGE_LOOPBACK_EN to add the lpbk
//   port. While lpbk is high, words move directly from the input FIFO to
//   the output FIFO.
module io_stream_bridge #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              sys_rst,
`ifdef IO_STREAM_BRIDGE_LOOPBACK_EN
    input  logic              lpbk,
`endif
    input  logic [DATA_W-1:0] host_in_data,
    input  logic              host_in_valid,
    output logic              host_in_ready,
    output logic [DATA_W-1:0] din,
    output logic              din_valid,
    input  logic              din_rd,
    input  logic [DATA_W-1:0] dout,
    input  logic              dout_wr,
    output logic [DATA_W-1:0] host_out_data,
    output logic              host_out_valid,
    input  logic              host_out_ready,
    output logic              ovf_err,
    output logic              udf_err
);

    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    // Input FIFO storage and state
    logic [DATA_W-1:0] r_in_mem [DEPTH];
    logic [AW-1:0]     r_in_wp;
    logic [AW-1:0]     r_in_rp;
    logic [AW:0]       r_in_cnt;

    // Output FIFO storage and state
    logic [DATA_W-1:0] r_out_mem [DEPTH];
    logic [AW-1:0]     r_out_wp;
    logic [AW-1:0]     r_out_rp;
    logic [AW:0]       r_out_cnt;

    logic              r_ovf_err;
    logic              r_udf_err;

    logic              w_lpbk;
    logic              w_in_empty;
    logic              w_in_full;
    logic              w_out_empty;
    logic              w_out_full;
    logic [DATA_W-1:0] w_in_head;
    logic              w_in_push;
    logic              w_in_pop;
    logic              w_out_push;
    logic              w_out_pop;
    logic [DATA_W-1:0] w_out_wdata;
    logic              w_lb_move;
    logic              w_set_ovf;
    logic              w_set_udf;

`ifdef IO_STREAM_BRIDGE_LOOPBACK_EN
    assign w_lpbk = lpbk;
`else
    assign w_lpbk = 1'b0;
`endif

    assign w_in_empty  = (r_in_cnt == '0);
    assign w_in_full   = (r_in_cnt == FULL_CNT);
    assign w_out_empty = (r_out_cnt == '0);
    assign w_out_full  = (r_out_cnt == FULL_CNT);
    assign w_in_head   = r_in_mem[r_in_rp];

    // Host-facing and processor-facing outputs, all derived from registered state
    assign host_in_ready  = !w_in_full;
    assign din_valid      = !w_in_empty && !w_lpbk;
    assign din            = w_in_empty ? '0 : w_in_head;
    assign host_out_valid = !w_out_empty;
    assign host_out_data  = w_out_empty ? '0 : r_out_mem[r_out_rp];
    assign ovf_err        = r_ovf_err;
    assign udf_err        = r_udf_err;

    // Push/pop decisions for both FIFOs. Loopback takes over the processor-side strobes.
    always_comb begin
        w_out_pop   = host_out_valid && host_out_ready;
        w_in_push   = host_in_valid && !w_in_full;
        w_lb_move   = w_lpbk && !w_in_empty && (!w_out_full || w_out_pop);
        w_in_pop    = 1'b0;
        w_out_push  = 1'b0;
        w_out_wdata = dout;
        w_set_ovf   = 1'b0;
        w_set_udf   = 1'b0;
        if (w_lpbk) begin
            w_in_pop    = w_lb_move;
            w_out_push  = w_lb_move;
            w_out_wdata = w_in_head;
        end else begin
            w_in_pop   = din_rd && !w_in_empty;
            w_set_udf  = din_rd && w_in_empty;
            // A full FIFO can still take a word if the host drains one this cycle
            w_out_push = dout_wr && (!w_out_full || w_out_pop);
            w_set_ovf  = dout_wr && w_out_full && !w_out_pop;
        end
    end

    // Input FIFO memory write. The contents do not need a reset.
    always_ff @(posedge clk) begin
        if (w_in_push) begin
            r_in_mem[r_in_wp] <= host_in_data;
        end
    end

    // Input FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            r_in_wp  <= '0;
            r_in_rp  <= '0;
            r_in_cnt <= '0;
        end else begin
            if (w_in_push) begin
                r_in_wp <= r_in_wp + PTR_ONE;
            end
            if (w_in_pop) begin
                r_in_rp <= r_in_rp + PTR_ONE;
            end
            case ({w_in_push, w_in_pop})
                2'b10:   r_in_cnt <= r_in_cnt + CNT_ONE;
                2'b01:   r_in_cnt <= r_in_cnt - CNT_ONE;
                default: r_in_cnt <= r_in_cnt;
            endcase
        end
    end

    // Output FIFO memory write. The contents do not need a reset.
    always_ff @(posedge clk) begin
        if (w_out_push) begin
            r_out_mem[r_out_wp] <= w_out_wdata;
        end
    end

    // Output FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            r_out_wp  <= '0;
            r_out_rp  <= '0;
            r_out_cnt <= '0;
        end else begin
            if (w_out_push) begin
                r_out_wp <= r_out_wp + PTR_ONE;
            end
            if (w_out_pop) begin
                r_out_rp <= r_out_rp + PTR_ONE;
            end
            case ({w_out_push, w_out_pop})
                2'b10:   r_out_cnt <= r_out_cnt + CNT_ONE;
                2'b01:   r_out_cnt <= r_out_cnt - CNT_ONE;
                default: r_out_cnt <= r_out_cnt;
            endcase
        end
    end

    // Sticky error flags. Only reset clears them.
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            r_ovf_err <= 1'b0;
            r_udf_err <= 1'b0;
        end else begin
            if (w_set_ovf) begin
                r_ovf_err <= 1'b1;
            end
            if (w_set_udf) begin
                r_udf_err <= 1'b1;
            end
        end
    end

endmodule

// File: doc/io_stream_bridge.md
Name: io_stream_bridge

Overview:
- Host-side endpoint for the processor's din/dout data buses; it handles the opposite end of the storedin and senddout transfers.
- Host writes 16-bit words into an input FIFO. The head word is presented on din for the processor's storedin instruction.
- Words the processor emits on dout during senddout are captured into an output FIFO and streamed back to the host.
- Both host sides use valid/ready handshakes. The processor side uses single-cycle strobes.

Parameters:
- DATA_W, 16, data word width; matches the processor din/dout bus width.
- DEPTH, 4, entries per FIFO; must be a power of two and at least 2.
- AW, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  input  1  system clock
- sys_rst  input  1  synchronous, active-high reset
- host_in_data  input  DATA_W  word from host
- host_in_valid  input  1  host word valid
- host_in_ready  output  1  input FIFO can accept a word (not full)
- din  output  DATA_W  input-FIFO head word to processor din; 0 when empty
- din_valid  output  1  input FIFO non-empty
- din_rd  input  1  processor consumed din this cycle (storedin strobe)
- dout  input  DATA_W  processor dout bus
- dout_wr  input  1  processor drove a new word on dout this cycle (senddout strobe)
- host_out_data  output  DATA_W  output-FIFO head word to host
- host_out_valid  output  1  output FIFO non-empty
- host_out_ready  input  1  host accepts host_out_data
- ovf_err  output  1  sticky: dout_wr dropped because output FIFO was full
- udf_err  output  1  sticky: din_rd while input FIFO empty

Behaviour:
- Reset (sys_rst=1 at posedge clk):
  - Pointers and counts go to 0; ovf_err and udf_err go to 0.
  - Outputs after reset: host_in_ready=1, din_valid=0, din=0, host_out_valid=0, host_out_data=0.
  - Reset mid-transfer discards all buffered words. FIFO memory contents need no clearing.
  - Reset overrides every push, pop and error update in the same cycle.
- Each FIFO holds a registered count (0..DEPTH), a write pointer and a read pointer. Pointers are AW bits wide and wrap naturally from DEPTH-1 to 0.
- Both FIFOs are first-word-fall-through: the head word is visible combinationally from registered memory and the read pointer.
- Input FIFO:
  - Push when host_in_valid && host_in_ready at posedge.
  - A word pushed at edge N appears on din/din_valid after edge N (1-cycle latency).
  - Pop when din_rd && din_valid.
  - host_in_ready = (count != DEPTH), derived from registered state only. A pop in the same cycle does not make a full FIFO accept a push.
  - Simultaneous push and pop when 0 < count < DEPTH: count unchanged, both pointers advance.
  - din_rd with count == 0: no state change except udf_err <= 1.
- Output FIFO:
  - Push when dout_wr, capturing dout.
  - Pop when host_out_valid && host_out_ready.
  - dout_wr when full with a host pop in the same cycle: both occur, count stays DEPTH, no error.
  - dout_wr when full without a pop: word dropped, ovf_err <= 1.
  - dout_wr when empty: word appears on host_out_data/host_out_valid after that edge (1-cycle latency).
- Sticky errors clear only on sys_rst.
- din and host_out_data read 0 whenever their FIFO is empty.

Optional Feature:
- Macro: IO_STREAM_BRIDGE_LOOPBACK_EN.
- Defined:
  - Adds input port lpbk (1 bit).
  - While lpbk=1, each cycle where the input FIFO is non-empty and the output FIFO can accept (not full, or popping this cycle) moves the input head word directly into the output FIFO.
  - In loopback mode, din_valid is forced 0, din_rd is ignored (no udf_err), and dout_wr is ignored (no ovf_err).
  - Switching lpbk between transfers loses no words.
- Not defined: no lpbk port; behaviour exactly as above.

Test Plan:
- Reset check: hold sys_rst 5 cycles with host_in_valid=1 and dout_wr=1 -> host_in_ready=1, din_valid=0, host_out_valid=0, both errors 0, no words stored.
- Fill the input FIFO: push 0x0011, 0x0022, 0x0033, 0x0044, then offer 0x0055 -> host_in_ready=0 after the 4th push and 0x0055 is not taken. Pulse din_rd 4 times -> din reads 0x0011..0x0044 in order, then din_valid=0.
- Input underflow: empty FIFO plus a 1-cycle din_rd -> udf_err=1 and stays 1 through later traffic until sys_rst.
- Output full with simultaneous pop: hold host_out_ready=0, dout_wr with 0xA001..0xA004 to fill. Next cycle dout_wr 0xA005 with host_out_ready=1 -> host receives 0xA001, FIFO holds 0xA002..0xA005, ovf_err=0.
- Output overflow: full FIFO, host_out_ready=0, dout_wr 0xBEEF -> ovf_err=1, 0xBEEF never appears on host_out_data.
- Loopback (macro defined): lpbk=1, push 0x1234 then 0x5678 -> host_out_data delivers 0x1234 then 0x5678 in order, din_valid stays 0, and din_rd pulses do not set udf_err.
